// File: rtl/flap_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : flap_display_scanner
// Brief    : Time-multiplexes four 4-bit flap indicators onto one segment bus
//            with anti-ghost blanking, dot-driven blink, lamp test and a
//            frame-start strobe.
// Revision : 1.0 - initial release
// ============================================================================
module flap_display_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int BLANK_CYCLES   = 50,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       async_nreset,
   input  logic       enable,
   input  logic       lamp_test,
   input  logic [3:0] segmented_input1,
   input  logic [3:0] segmented_input2,
   input  logic [3:0] segmented_input3,
   input  logic [3:0] segmented_input4,
   output logic [3:0] seg,
   output logic [3:0] digit_enable,
   output logic       frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [CW-1:0] c_cnt_last   = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] c_frame_last = FW'(BLINK_FRAMES - 1);
   localparam logic [3:0]    c_seg_off    = (SEG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
   localparam logic [3:0]    c_dig_off    = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [FW-1:0] r_frame_cnt;
   logic          r_blink;
   logic [3:0]    r_snap;
   logic          r_snap_lt;

   logic [3:0]    w_in;
   logic [3:0]    w_val;
   logic          w_lt;
   logic [3:0]    w_disp;
   logic [3:0]    w_onehot;
   logic          w_first;
   logic          w_wrap;
   logic          w_drive;

   always_comb begin
      w_in = segmented_input1;
      case (r_idx)
         2'd0:    w_in = segmented_input1;
         2'd1:    w_in = segmented_input2;
         2'd2:    w_in = segmented_input3;
         default: w_in = segmented_input4;
      endcase
   end

   assign w_first  = (r_cnt == '0);
   assign w_wrap   = (r_cnt == c_cnt_last);
   assign w_onehot = 4'b0001 << r_idx;

   // On the snapshot cycle the live input is used so a zero-length blank
   // phase still shows this slot's value rather than the previous one.
   assign w_val = w_first ? w_in      : r_snap;
   assign w_lt  = w_first ? lamp_test : r_snap_lt;

   always_comb begin
      w_disp = w_val;
      if (w_lt) begin
         w_disp = 4'b1111;
      end else if (w_val[3] && r_blink) begin
         w_disp = 4'b1000;
      end
   end

   generate
      if (BLANK_CYCLES == 0) begin : g_no_blank
         assign w_drive = 1'b1;
      end else begin : g_blank
         localparam logic [CW-1:0] c_blank = CW'(BLANK_CYCLES);
         assign w_drive = (r_cnt >= c_blank);
      end
   endgenerate

   always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
         r_cnt        <= '0;
         r_idx        <= 2'd0;
         r_frame_cnt  <= '0;
         r_blink      <= 1'b0;
         r_snap       <= 4'h0;
         r_snap_lt    <= 1'b0;
         seg          <= c_seg_off;
         digit_enable <= c_dig_off;
         frame_start  <= 1'b0;
      end else if (!enable) begin
         r_cnt        <= '0;
         r_idx        <= 2'd0;
         r_frame_cnt  <= '0;
         r_blink      <= 1'b0;
         seg          <= c_seg_off;
         digit_enable <= c_dig_off;
         frame_start  <= 1'b0;
      end else begin
         r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
         if (w_wrap) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
               if (r_frame_cnt == c_frame_last) begin
                  r_frame_cnt <= '0;
                  r_blink     <= ~r_blink;
               end else begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end
            end
         end
         if (w_first) begin
            r_snap    <= w_in;
            r_snap_lt <= lamp_test;
         end
         seg          <= w_drive ? (w_disp ^ c_seg_off)   : c_seg_off;
         digit_enable <= w_drive ? (w_onehot ^ c_dig_off) : c_dig_off;
         frame_start  <= w_first && (r_idx == 2'd0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_flap_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_flap_display_scanner
// Brief    : Directed self-checking bench for flap_display_scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flap_display_scanner;

   localparam int SD = 8;
   localparam int BC = 2;
   localparam int BF = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_n_al;
   logic       enable;
   logic       lamp_test;
   logic [3:0] in1, in2, in3, in4;
   logic [3:0] seg, dig, seg_al, dig_al;
   logic       fs, fs_al;

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] ev [4];

   always #5 clk = ~clk;

   flap_display_scanner #(
      .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .async_nreset(rst_n), .enable(enable), .lamp_test(lamp_test),
      .segmented_input1(in1), .segmented_input2(in2),
      .segmented_input3(in3), .segmented_input4(in4),
      .seg(seg), .digit_enable(dig), .frame_start(fs)
   );

   flap_display_scanner #(
      .SCAN_DIV(SD), .BLANK_CYCLES(BC), .BLINK_FRAMES(BF),
      .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .async_nreset(rst_n_al), .enable(enable), .lamp_test(lamp_test),
      .segmented_input1(in1), .segmented_input2(in2),
      .segmented_input3(in3), .segmented_input4(in4),
      .seg(seg_al), .digit_enable(dig_al), .frame_start(fs_al)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected one-hot enable at sample j after a frame_start sample (j=0).
   function automatic logic [3:0] exp_dig(input int j);
      int p;
      int d;
      logic [3:0] one;
      p   = j % SD;
      d   = (j / SD) % 4;
      one = 4'b0001;
      return (p < BC) ? 4'b0000 : (one << d);
   endfunction

   task automatic wait_fs(input bit use_al);
      int k;
      for (k = 0; k < 64; k++) begin
         tick();
         if ((use_al ? fs_al : fs) === 1'b1) break;
      end
      n_cmp++;
      if (k == 64) begin
         n_bad++;
         $display("FAIL wait_frame_start: got no pulse in 64 cycles, required one");
      end
   endtask

   task automatic restart();
      enable = 1'b0;
      tick();
      tick();
      enable = 1'b1;
      wait_fs(1'b0);
   endtask

   task automatic test_reset();
      n_cmp++;
      if (seg !== 4'h0 || dig !== 4'h0 || fs !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_high: got seg=%h dig=%h fs=%b required 0/0/0", seg, dig, fs);
      end
      n_cmp++;
      if (seg_al !== 4'hF || dig_al !== 4'hF || fs_al !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_low: got seg=%h dig=%h fs=%b required f/f/0", seg_al, dig_al, fs_al);
      end
   endtask

   task automatic test_scan();
      logic [3:0] es;
      ev = '{4'h1, 4'h2, 4'h4, 4'h3};
      in1 = 4'h1; in2 = 4'h2; in3 = 4'h4; in4 = 4'h3; lamp_test = 1'b0;
      restart();
      for (int j = 0; j < 32; j++) begin
         if (j > 0) tick();
         es = ((j % SD) < BC) ? 4'h0 : ev[j / SD];
         n_cmp++;
         if (dig !== exp_dig(j)) begin
            n_bad++;
            $display("FAIL scan_dig j=%0d: got %b required %b", j, dig, exp_dig(j));
         end
         n_cmp++;
         if (seg !== es) begin
            n_bad++;
            $display("FAIL scan_seg j=%0d: got %h required %h", j, seg, es);
         end
         n_cmp++;
         if (fs !== (j == 0)) begin
            n_bad++;
            $display("FAIL scan_fs j=%0d: got %b required %b", j, fs, (j == 0));
         end
      end
      tick();
      n_cmp++;
      if (fs !== 1'b1) begin
         n_bad++;
         $display("FAIL scan_fs_period: got %b required 1 at 32 cycles", fs);
      end
   endtask

   task automatic test_blink();
      logic [3:0] es;
      int f;
      ev = '{4'h1, 4'hD, 4'h4, 4'h3};
      in2 = 4'hD;
      restart();
      for (int j = 0; j < 128; j++) begin
         if (j > 0) tick();
         f  = j / 32;
         es = ev[(j / SD) % 4];
         if ((j / SD) % 4 == 1 && ((f / 2) % 2) == 1) es = 4'h8;
         if ((j % SD) < BC) es = 4'h0;
         n_cmp++;
         if (seg !== es || dig !== exp_dig(j)) begin
            n_bad++;
            $display("FAIL blink j=%0d: got seg=%h dig=%b required seg=%h dig=%b",
                     j, seg, dig, es, exp_dig(j));
         end
      end
   endtask

   task automatic test_lamp();
      logic [3:0] es;
      lamp_test = 1'b1;
      in2 = 4'hD;
      restart();
      for (int j = 0; j < 128; j++) begin
         if (j > 0) tick();
         es = ((j % SD) < BC) ? 4'h0 : 4'hF;
         n_cmp++;
         if (seg !== es || dig !== exp_dig(j)) begin
            n_bad++;
            $display("FAIL lamp j=%0d: got seg=%h dig=%b required seg=%h dig=%b",
                     j, seg, dig, es, exp_dig(j));
         end
      end
      lamp_test = 1'b0;
   endtask

   task automatic test_snapshot();
      in1 = 4'h1; in2 = 4'h2;
      restart();
      for (int j = 1; j < 40; j++) begin
         tick();
         if (j == 3) in1 = 4'h6;
         if (j >= 4 && j < 8) begin
            n_cmp++;
            if (seg !== 4'h1 || dig !== 4'b0001) begin
               n_bad++;
               $display("FAIL snap_hold j=%0d: got seg=%h dig=%b required 1/0001", j, seg, dig);
            end
         end
         if (j >= 34) begin
            n_cmp++;
            if (seg !== 4'h6 || dig !== 4'b0001) begin
               n_bad++;
               $display("FAIL snap_next j=%0d: got seg=%h dig=%b required 6/0001", j, seg, dig);
            end
         end
      end
   endtask

   task automatic test_enable_drop();
      logic [3:0] es;
      ev = '{4'h1, 4'h2, 4'h4, 4'h3};
      in1 = 4'h1;
      restart();
      for (int j = 1; j <= 20; j++) tick();
      n_cmp++;
      if (seg !== 4'h4 || dig !== 4'b0100) begin
         n_bad++;
         $display("FAIL en_before: got seg=%h dig=%b required 4/0100", seg, dig);
      end
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_cmp++;
         if (seg !== 4'h0 || dig !== 4'h0 || fs !== 1'b0) begin
            n_bad++;
            $display("FAIL en_off k=%0d: got seg=%h dig=%b fs=%b required 0/0000/0", k, seg, dig, fs);
         end
      end
      enable = 1'b1;
      for (int j = 0; j < 10; j++) begin
         tick();
         es = ((j % SD) < BC) ? 4'h0 : ev[j / SD];
         n_cmp++;
         if (seg !== es || dig !== exp_dig(j) || fs !== (j == 0)) begin
            n_bad++;
            $display("FAIL en_restart j=%0d: got seg=%h dig=%b fs=%b required %h/%b/%b",
                     j, seg, dig, fs, es, exp_dig(j), (j == 0));
         end
      end
   endtask

   task automatic test_async_reset_active_low();
      logic [3:0] es;
      wait_fs(1'b1);
      for (int j = 1; j <= 4; j++) tick();
      n_cmp++;
      if (seg_al !== 4'hE || dig_al !== 4'hE) begin
         n_bad++;
         $display("FAIL al_drive: got seg=%h dig=%h required e/e", seg_al, dig_al);
      end
      #2 rst_n_al = 1'b0;
      #1;
      n_cmp++;
      if (seg_al !== 4'hF || dig_al !== 4'hF || fs_al !== 1'b0) begin
         n_bad++;
         $display("FAIL al_async_reset: got seg=%h dig=%h fs=%b required f/f/0", seg_al, dig_al, fs_al);
      end
      tick();
      rst_n_al = 1'b1;
      for (int j = 0; j < 10; j++) begin
         tick();
         es = ((j % SD) < BC) ? 4'h0 : ev[j / SD];
         n_cmp++;
         if (seg_al !== ~es || dig_al !== ~exp_dig(j) || fs_al !== (j == 0)) begin
            n_bad++;
            $display("FAIL al_restart j=%0d: got seg=%h dig=%h fs=%b required %h/%h/%b",
                     j, seg_al, dig_al, fs_al, ~es, ~exp_dig(j), (j == 0));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; rst_n_al = 1'b0; enable = 1'b0; lamp_test = 1'b0;
      in1 = 4'h1; in2 = 4'h2; in3 = 4'h4; in4 = 4'h3;
      #12;
      test_reset();
      tick();
      rst_n = 1'b1; rst_n_al = 1'b1;
      tick();
      test_scan();
      test_blink();
      test_lamp();
      test_snapshot();
      test_enable_drop();
      test_async_reset_active_low();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/flap_display_scanner.md
Name: flap_display_scanner

Overview:
Downstream stage of the four-indicator flap display top. Takes the four 4-bit segmented outputs (bit3 = selection dot, bits2:0 = down/hor/up) and time-multiplexes them onto one shared 4-line segment bus with one-hot digit enables.
Adds anti-ghosting blanking, blinking of the selected indicator's flap segments, lamp test and a frame-start strobe.

Parameters:
SCAN_DIV, 1000, clock cycles per digit slot; legal range 2 and up.
BLANK_CYCLES, 50, cycles at the start of each slot with all outputs inactive; must satisfy 0 <= BLANK_CYCLES < SCAN_DIV.
BLINK_FRAMES, 64, full 4-digit frames per blink half-period; must be 1 or more.
SEG_ACTIVE_LOW, 0, 1 = seg outputs inverted at the pin.
DIG_ACTIVE_LOW, 0, 1 = digit_enable outputs inverted at the pin.

Ports:
clk  input  1  system clock
async_nreset  input  1  asynchronous active-low reset
enable  input  1  scanning enable
lamp_test  input  1  force all four segments on
segmented_input1  input  4  digit 0 value {dot, down, hor, up}
segmented_input2  input  4  digit 1 value
segmented_input3  input  4  digit 2 value
segmented_input4  input  4  digit 3 value
seg  output  4  shared segment bus {dot, down, hor, up}
digit_enable  output  4  one-hot digit select; bit i drives digit i
frame_start  output  1  one-cycle pulse on the first cycle of the digit-0 slot

Behaviour:
- Reset: slot counter, digit index, frame counter and blink phase all 0. Snapshot is 0. seg and digit_enable are at their inactive level: 0, or all-ones if the matching ACTIVE_LOW parameter is 1. frame_start is 0.
- All outputs are driven from registers. There is no combinational path from any input to any output.
- Slot counter c counts 0..SCAN_DIV-1 and then wraps to 0. At each wrap the digit index advances 0->1->2->3->0.
- Snapshot: on the cycle where c==0, the block registers the current digit's segmented_input and lamp_test. These values hold for the whole slot. Input changes mid-slot are not visible until that digit's next slot.
- Slot phases:
  - BLANK, for c in [0, BLANK_CYCLES): digit_enable is all inactive and seg is inactive.
  - DRIVE, for c in [BLANK_CYCLES, SCAN_DIV): digit_enable has only bit[index] active, and seg carries the displayed value.
  - With BLANK_CYCLES=0 there is no blank phase.
- Output registers update one cycle after the counter state that selects them. The visible slot therefore lags the counter by exactly 1 cycle. A bench should measure phase lengths, not absolute offsets.
- Displayed value:
  - If the lamp_test snapshot is 1: 4'b1111.
  - Else if the dot is 1 and blink phase is 1: {1, 3'b000}. The dot stays lit and the flap segments go dark.
  - Else: the snapshot value.
- Blink: the frame counter counts completed frames, incrementing at the digit 3->0 wrap. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- frame_start: a registered pulse with the same 1-cycle lag as the outputs. It is high for exactly one cycle per frame, at the start of the digit-0 slot, and is not asserted while enable=0.
- enable=0: outputs are forced inactive on the next cycle. Slot counter, digit index, frame counter and blink phase are held at 0.
- enable 0->1: scanning restarts at digit 0, c=0, with a blank phase first. frame_start fires on the first slot.
- Simultaneous events:
  - lamp_test overrides blink.
  - A dot on several digits blinks all of them in the same phase.
  - An enable drop on a wrap cycle wins: counters clear.
- Reset asserted mid-slot: all outputs go inactive immediately (asynchronously). Scanning restarts from digit 0 after release.

Test Plan:
1. Params SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, enable=1, inputs 4'h1/4'h2/4'h4/4'h3.
   -> digit_enable follows 0000,0000, then 0001 for 6 cycles, and repeats for 0010, 0100, 1000.
   -> seg = 1, 2, 4, 3 during each DRIVE phase.
   -> frame_start pulses every 32 cycles.
2. Same params, segmented_input2 = 4'b1101.
   -> Digit 1 shows 1101 for frames 0-1, then 1000 for frames 2-3, alternating every 2 frames.
   -> The other digits are unaffected.
3. lamp_test=1 with a blinking dot present.
   -> Every digit shows 1111 during DRIVE, in every frame.
   -> Blanking is still present.
4. Change segmented_input1 from 4'h1 to 4'h6 at c=4 of the digit-0 slot.
   -> The rest of that slot still shows 1.
   -> The next digit-0 slot shows 6.
5. Drop enable mid-slot of digit 2, hold 5 cycles, then re-raise.
   -> Outputs go inactive 1 cycle after the drop.
   -> After re-enable: a 2-cycle blank, then digit 0 driven, with a frame_start pulse.
6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1; assert async_nreset low mid-DRIVE.
   -> seg=4'b1111 and digit_enable=4'b1111 immediately, without waiting for a clock edge.
   -> After release, the scan restarts at digit 0 with inverted active levels.
